// File: rtl/wide_mem_loader.sv
// Purpose : stream a 64-bit valid/ready beat sequence into consecutive words of the wide memory port.
// Latency : memory write presented 1 cycle after each beat handshake; done 1 cycle after the last beat.
// Backpr. : s_ready high for the whole transfer (forced low by abort); cmd_ready high only when idle.
//
// Optional feature macro: LOADER_CHECKSUM_EN adds the 32-bit running checksum output.
//
// Ports:
//   clk, rstn                      single clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake carrying cmd_addr (start word) and cmd_len (beats, 0 legal)
//   s_valid/s_ready/s_data/s_hmask data beat stream; s_hmask bit0 = [31:0], bit1 = [63:32]
//   abort                          ends a running transfer early (ignored when idle)
//   mem_en/mem_we/mem_addr/mem_din wide memory port drive (registered)
//   busy, done, aborted            status: busy through load and completion, one-cycle done/aborted pulses
//   checksum                       sum of both 32-bit halves of every accepted beat (macro builds only)

module wide_mem_loader #(
  parameter int AW = 11,
  parameter int LW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [63:0]   s_data,
  input  logic [1:0]    s_hmask,
  input  logic          abort,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_din,
  output logic          busy,
  output logic          done,
  output logic          aborted
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_remain;

  logic w_cmd_acc;
  logic w_beat_acc;

  // Handshake readies are decoded straight from state so a beat can be taken the cycle after accept.
  assign cmd_ready  = (r_state == ST_IDLE);
  assign s_ready    = (r_state == ST_LOAD) && !abort;
  assign w_cmd_acc  = cmd_valid && cmd_ready;
  assign w_beat_acc = s_valid && s_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 2'b00;
      mem_addr <= '0;
      mem_din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      // Strobes default low; mem_addr/mem_din hold between writes.
      mem_en  <= 1'b0;
      mem_we  <= 2'b00;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            r_addr   <= cmd_addr;
            r_remain <= cmd_len;
            busy     <= 1'b1;
            if (cmd_len == '0) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // abort wins over a same-cycle beat (s_ready is already low for it).
          if (abort) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (w_beat_acc) begin
            mem_en   <= 1'b1;
            mem_we   <= s_hmask;
            mem_addr <= r_addr;
            mem_din  <= s_data;
            r_addr   <= r_addr + 1'b1;   // wraps naturally at 2^AW
            r_remain <= r_remain - 1'b1;
            if (r_remain == LW'(1)) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Mask does not gate the sum: every accepted beat contributes both halves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      checksum <= '0;
    end else if (w_cmd_acc) begin
      checksum <= '0;
    end else if (w_beat_acc) begin
      checksum <= checksum + s_data[31:0] + s_data[63:32];
    end
  end
`endif

endmodule

// File: tb/tb_wide_mem_loader.sv
// Purpose : randomized and directed stimulus for wide_mem_loader against a transaction-level model.
// Latency : model expects each write one cycle after its beat and done with the last write.
// Backpr. : bench drives s_valid gaps and aborts; expects s_ready high throughout a transfer.

module tb_wide_mem_loader;

  localparam int AW = 11;
  localparam int LW = 12;

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic [1:0]    s_hmask;
  logic          abort;
  logic          mem_en;
  logic [1:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_din;
  logic          busy;
  logic          done;
  logic          aborted;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  wide_mem_loader #(.AW(AW), .LW(LW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_hmask   (s_hmask),
    .abort     (abort),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory images: the model writes what should land, the monitor what the DUT drove.
  logic [63:0] ref_mem [2048];
  logic [63:0] dut_mem [2048];

  always @(negedge clk) begin
    if (rstn === 1'b1 && mem_en === 1'b1) begin
      if (mem_we[0]) dut_mem[mem_addr][31:0]  = mem_din[31:0];
      if (mem_we[1]) dut_mem[mem_addr][63:32] = mem_din[63:32];
    end
  end

  // Expected held values of the write port between writes.
  logic [AW-1:0] exp_addr;
  logic [63:0]   exp_din;

  // Optional directed patterns; when empty, values are random (rnd=1) or default.
  bit          vpat [$];
  logic [1:0]  mpat [$];
  logic [63:0] dpat [$];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_en"},  mem_en,   0);
    check({tag, "_mem_we"},  mem_we,   0);
    check({tag, "_addr"},    mem_addr, 0);
    check({tag, "_din"},     mem_din,  0);
    check({tag, "_busy"},    busy,     0);
    check({tag, "_done"},    done,     0);
    check({tag, "_aborted"}, aborted,  0);
    check({tag, "_cmd_rdy"}, cmd_ready, 1);
    check({tag, "_s_rdy"},   s_ready,  0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_csum"},    checksum, 0);
`endif
  endtask

  // One transfer: abort_beat = beat index that carries abort (-1 none),
  // rst_beat = beat count after which reset is pulsed mid-transfer (-1 none).
  task automatic run_xfer(input logic [AW-1:0] a, input logic [LW-1:0] n,
                          input int abort_beat, input int rnd, input int rst_beat);
    int          taken;
    int          cyc;
    bit          fin;
    bit          v;
    bit          abt;
    bit          hs;
    logic [1:0]  m;
    logic [63:0] d;
    logic [31:0] sum;
    taken = 0;
    cyc   = 0;
    sum   = '0;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    abort     = 1'($urandom_range(0, 1));   // abort while idle must be ignored
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    check("s_ready_idle", s_ready, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    check("busy_after_acc", busy, 1);
    check("done_after_acc", done, (n == 0));
    check("aborted_after_acc", aborted, 0);
    check("mem_en_after_acc", mem_en, 0);
    check("cmd_ready_busy", cmd_ready, 0);
    fin = (n == 0);

    while (!fin) begin
      @(negedge clk);
      if (taken == rst_beat) begin
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_addr = '0;
        exp_din  = '0;
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      v = (vpat.size() > 0) ? vpat.pop_front() : (rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      m = (mpat.size() > 0) ? mpat.pop_front() : (rnd != 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      d = (dpat.size() > 0) ? dpat.pop_front() : {$urandom, $urandom};
      abt = v && (taken == abort_beat);
      s_valid   = v;
      s_data    = d;
      s_hmask   = m;
      abort     = abt;
      cmd_valid = 1'($urandom_range(0, 1));   // must be held off while busy
      #1;
      check("s_ready_load", s_ready, !abt);
      check("cmd_ready_load", cmd_ready, 0);
      hs = v && !abt;
      @(posedge clk);
      #1;
      s_valid   = 1'b0;
      abort     = 1'b0;
      cmd_valid = 1'b0;
      if (hs) begin
        exp_addr = a + AW'(taken);
        exp_din  = d;
        if (m[0]) ref_mem[exp_addr][31:0]  = d[31:0];
        if (m[1]) ref_mem[exp_addr][63:32] = d[63:32];
        sum = sum + d[31:0] + d[63:32];
        taken++;
      end
      check("mem_en", mem_en, hs);
      check("mem_we", mem_we, hs ? m : 2'b00);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_din", mem_din, exp_din);
      fin = abt || (taken == int'(n));
      check("done", done, fin);
      check("aborted", aborted, abt);
      check("busy_load", busy, 1);
      cyc++;
      if (cyc > 4000) begin
        check("xfer_timeout", 1, 0);
        fin = 1'b1;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    check("checksum", checksum, sum);
`endif
    @(posedge clk);
    #1;
    check("done_after", done, 0);
    check("aborted_after", aborted, 0);
    check("busy_after", busy, 0);
    check("mem_en_after", mem_en, 0);
    check("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    int diffs;
    int len;
    int ab;
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = '0;
      dut_mem[i] = '0;
    end
    exp_addr  = '0;
    exp_din   = '0;
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_hmask   = 2'b00;
    abort     = 1'b0;
    #2;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    rstn = 1'b1;

    // Basic: four full beats from 0x010.
    dpat = '{64'h1111, 64'h2222, 64'h3333, 64'h4444};
    run_xfer(11'h010, 12'd4, -1, 0, -1);

    // Address wrap past the top word.
    run_xfer(11'h7FE, 12'd4, -1, 0, -1);

    // Valid gaps: 1,0,0,1,1 for three beats.
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_xfer(11'h100, 12'd3, -1, 0, -1);

    // Per-half masks, including an all-off beat that still advances.
    mpat = '{2'b01, 2'b10, 2'b00};
    run_xfer(11'h200, 12'd3, -1, 0, -1);

    // Zero length, then abort on the third beat of eight.
    run_xfer(11'h300, 12'd0, -1, 0, -1);
    run_xfer(11'h310, 12'd8, 2, 0, -1);

    // Random transfers with gaps, masks and occasional aborts.
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(0, 40);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      run_xfer(11'($urandom), 12'(len), ab, 1, -1);
    end

    // Reset mid-load, then a fresh command must be accepted.
    run_xfer(11'h400, 12'd10, -1, 0, 3);
    run_xfer(11'h500, 12'd5, -1, 1, -1);

    diffs = 0;
    for (int i = 0; i < 2048; i++) begin
      if (ref_mem[i] !== dut_mem[i]) diffs++;
    end
    check("mem_image_diffs", diffs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
